bru_queue: RTL and testbench

- Parametrised branch resolution unit with a small in-order result queue.
- Resolves conditional branches and JIRL, computes the real target, and flags mispredict against the front-end's predicted direction and target.
- Results are buffered and handed to the ROB over a valid/ready handshake, so a stalled commit path does not drop resolutions.
- Sits in the back end between the branch issue queue and the ROB, and honours flush_back.

---
 rtl/bru_queue.sv | 154 +++++++++++++++
 tb/tb_bru_queue.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bru_queue.sv
// Branch resolution unit: resolves conditional branches and JIRL, flags mispredicts,
// and buffers results in order for the ROB behind a valid/ready handshake.
`ifndef BRU_CONF_DEFS
`define BRU_CONF_DEFS
`define BEQ_CONF  4'd1
`define BNE_CONF  4'd2
`define BLT_CONF  4'd3
`define BGE_CONF  4'd4
`define BLTU_CONF 4'd5
`define BGEU_CONF 4'd6
`define JIRL_CONF 4'd7
`endif

module bru_queue #(
  parameter int XLEN   = 32,
  parameter int TAG_W  = 6,
  parameter int CONF_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_back,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CONF_W-1:0] conf,
  input  logic [XLEN-1:0]   dataj,
  input  logic [XLEN-1:0]   datad_old,
  input  logic [XLEN-1:0]   imm,
  input  logic [XLEN-1:0]   pc,
  input  logic              pred_taken,
  input  logic [XLEN-1:0]   target_predict,
  input  logic [TAG_W-1:0]  tag_rob,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [TAG_W-1:0]  out_tag_rob,
  output logic              out_taken,
  output logic              out_mispredict,
  output logic              out_is_jirl,
  output logic [XLEN-1:0]   out_target_real,
  output logic [31:0]       mispredict_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = TAG_W + XLEN + 3;
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [XLEN-1:0]  PC_STEP  = XLEN'(32'd4);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(32'd1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(32'd1);

  logic             taken_s;
  logic             is_jirl_s;
  logic             cond_s;
  logic             mispredict_s;
  logic [XLEN-1:0]  target_s;
  logic [ENT_W-1:0] entry_s;
  logic [ENT_W-1:0] head_s;
  logic             push_s;
  logic             pop_s;
  logic             out_valid_s;
  logic             in_ready_s;

  logic [ENT_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [PTR_W:0]   count_r;
  logic [31:0]      cnt_r;

  // Direction decode per branch kind
  always_comb begin
    taken_s   = 1'b0;
    is_jirl_s = 1'b0;
    cond_s    = 1'b1;
    case (conf)
      `BEQ_CONF:  taken_s = (dataj == datad_old);
      `BNE_CONF:  taken_s = (dataj != datad_old);
      `BLT_CONF:  taken_s = ($signed(dataj) <  $signed(datad_old));
      `BGE_CONF:  taken_s = ($signed(dataj) >= $signed(datad_old));
      `BLTU_CONF: taken_s = (dataj <  datad_old);
      `BGEU_CONF: taken_s = (dataj >= datad_old);
      `JIRL_CONF: begin
        taken_s   = 1'b1;
        is_jirl_s = 1'b1;
        cond_s    = 1'b0;
      end
      default:    cond_s = 1'b0;
    endcase
  end

  // Real target and mispredict against the front-end prediction
  always_comb begin
    if (is_jirl_s) begin
      target_s = dataj + imm;
    end else if (taken_s) begin
      target_s = pc + imm;
    end else begin
      target_s = pc + PC_STEP;
    end
    if (cond_s) begin
      mispredict_s = (taken_s != pred_taken) ||
                     (taken_s && pred_taken && (target_s != target_predict));
    end else if (is_jirl_s) begin
      mispredict_s = (target_s != target_predict);
    end else begin
      mispredict_s = pred_taken;
    end
  end

  assign entry_s     = {tag_rob, taken_s, mispredict_s, is_jirl_s, target_s};
  assign out_valid_s = (count_r != {(PTR_W + 1){1'b0}});
  assign in_ready_s  = (count_r != FULL_CNT);
  assign push_s      = in_valid & in_ready_s;
  assign pop_s       = out_valid_s & out_ready;
  // Empty queue presents all-zero outputs
  assign head_s      = out_valid_s ? mem_r[head_r] : {ENT_W{1'b0}};

  assign {out_tag_rob, out_taken, out_mispredict, out_is_jirl, out_target_real} = head_s;
  assign in_ready       = in_ready_s;
  assign out_valid      = out_valid_s;
  assign mispredict_cnt = cnt_r;

  // Queue storage, pointers, occupancy and mispredict counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {(PTR_W + 1){1'b0}};
      cnt_r   <= 32'd0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {ENT_W{1'b0}};
      end
    end else if (flush_back) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {(PTR_W + 1){1'b0}};
    end else begin
      if (push_s) begin
        mem_r[tail_r] <= entry_s;
        tail_r        <= tail_r + PTR_ONE;
      end
      if (pop_s) begin
        head_r <= head_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
      if (pop_s && out_mispredict && (cnt_r != 32'hFFFF_FFFF)) begin
        cnt_r <= cnt_r + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_bru_queue.sv
// Scoreboard bench for bru_queue: a reference model predicts each accepted op,
// and an output monitor compares the queue head against the scoreboard.
`ifndef BRU_CONF_DEFS
`define BRU_CONF_DEFS
`define BEQ_CONF  4'd1
`define BNE_CONF  4'd2
`define BLT_CONF  4'd3
`define BGE_CONF  4'd4
`define BLTU_CONF 4'd5
`define BGEU_CONF 4'd6
`define JIRL_CONF 4'd7
`endif

module tb_bru_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_back;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  conf;
  logic [31:0] dataj, datad_old, imm, pc, target_predict;
  logic        pred_taken;
  logic [5:0]  tag_rob;
  logic        out_valid, out_ready;
  logic [5:0]  out_tag_rob;
  logic        out_taken, out_mispredict, out_is_jirl;
  logic [31:0] out_target_real;
  logic [31:0] mispredict_cnt;

  bru_queue #(.XLEN(32), .TAG_W(6), .CONF_W(4), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush_back(flush_back),
    .in_valid(in_valid), .in_ready(in_ready), .conf(conf),
    .dataj(dataj), .datad_old(datad_old), .imm(imm), .pc(pc),
    .pred_taken(pred_taken), .target_predict(target_predict), .tag_rob(tag_rob),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag_rob(out_tag_rob),
    .out_taken(out_taken), .out_mispredict(out_mispredict), .out_is_jirl(out_is_jirl),
    .out_target_real(out_target_real), .mispredict_cnt(mispredict_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  tag;
    logic        taken;
    logic        mis;
    logic        jirl;
    logic [31:0] target;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_cnt = 32'd0;
  logic [5:0]  tag_ctr = 6'd0;
  bit          rand_rdy = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain 64-bit arithmetic, results truncated to 32 bits
  function automatic exp_t model(input logic [3:0] c, input logic [31:0] dj, input logic [31:0] dd,
                                 input logic [31:0] im, input logic [31:0] p, input logic pt,
                                 input logic [31:0] tp, input logic [5:0] tg);
    exp_t        e;
    longint      sj, sd, uj, ud;
    logic [63:0] sum;
    bit          is_cond;
    sj = longint'($signed(dj));
    sd = longint'($signed(dd));
    uj = longint'({32'd0, dj});
    ud = longint'({32'd0, dd});
    is_cond = c inside {`BEQ_CONF, `BNE_CONF, `BLT_CONF, `BGE_CONF, `BLTU_CONF, `BGEU_CONF};
    e.tag  = tg;
    e.jirl = (c == `JIRL_CONF);
    case (c)
      `BEQ_CONF:  e.taken = (uj == ud);
      `BNE_CONF:  e.taken = (uj != ud);
      `BLT_CONF:  e.taken = (sj < sd);
      `BGE_CONF:  e.taken = (sj >= sd);
      `BLTU_CONF: e.taken = (uj < ud);
      `BGEU_CONF: e.taken = (uj >= ud);
      `JIRL_CONF: e.taken = 1'b1;
      default:    e.taken = 1'b0;
    endcase
    if (e.jirl)       sum = {32'd0, dj} + {32'd0, im};
    else if (e.taken) sum = {32'd0, p} + {32'd0, im};
    else              sum = {32'd0, p} + 64'd4;
    e.target = sum[31:0];
    if (is_cond)     e.mis = (e.taken != pt) || (e.taken && pt && (e.target != tp));
    else if (e.jirl) e.mis = (e.target != tp);
    else             e.mis = pt;
    return e;
  endfunction

  // Input monitor: record accepted ops, drop everything on flush
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        if (flush_back) sb.delete();
        else if (in_valid && in_ready)
          sb.push_back(model(conf, dataj, datad_old, imm, pc, pred_taken, target_predict, tag_rob));
      end
    end
  end

  // Output monitor: compare head against scoreboard, pop on handshake
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("out_valid", {63'd0, out_valid}, {63'd0, sb.size() != 0});
        chk("in_ready", {63'd0, in_ready}, {63'd0, sb.size() != DEPTH});
        chk("mispredict_cnt", {32'd0, mispredict_cnt}, {32'd0, model_cnt});
        if (out_valid && sb.size() > 0) begin
          e = sb[0];
          chk("out_tag_rob", {58'd0, out_tag_rob}, {58'd0, e.tag});
          chk("out_taken", {63'd0, out_taken}, {63'd0, e.taken});
          chk("out_mispredict", {63'd0, out_mispredict}, {63'd0, e.mis});
          chk("out_is_jirl", {63'd0, out_is_jirl}, {63'd0, e.jirl});
          chk("out_target_real", {32'd0, out_target_real}, {32'd0, e.target});
          if (out_ready && !flush_back) begin
            void'(sb.pop_front());
            if (e.mis && model_cnt != 32'hFFFF_FFFF) model_cnt = model_cnt + 32'd1;
          end
        end else if (!out_valid) begin
          chk("out_zero", {23'd0, out_tag_rob, out_taken, out_mispredict, out_is_jirl, out_target_real}, 64'd0);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic wait_accept();
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1 at %0t", $time);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drive(input logic [3:0] c, input logic [31:0] dj, input logic [31:0] dd,
                       input logic [31:0] im, input logic [31:0] p, input logic pt,
                       input logic [31:0] tp);
    conf = c; dataj = dj; datad_old = dd; imm = im; pc = p;
    pred_taken = pt; target_predict = tp; tag_rob = tag_ctr;
    tag_ctr = tag_ctr + 6'd1;
    in_valid = 1'b1;
  endtask

  task automatic send(input logic [3:0] c, input logic [31:0] dj, input logic [31:0] dd,
                      input logic [31:0] im, input logic [31:0] p, input logic pt,
                      input logic [31:0] tp);
    drive(c, dj, dd, im, p, pt, tp);
    wait_accept();
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d entries expected 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    exp_t        e;
    logic [3:0]  c;
    logic [31:0] dj, dd, im, p, tp;
    rst = 1'b0; flush_back = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    conf = 4'd0; dataj = 32'd0; datad_old = 32'd0; imm = 32'd0; pc = 32'd0;
    pred_taken = 1'b0; target_predict = 32'd0; tag_rob = 6'd0;
    #12;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_cnt", {32'd0, mispredict_cnt}, 64'd0);
    chk("rst_outs", {23'd0, out_tag_rob, out_taken, out_mispredict, out_is_jirl, out_target_real}, 64'd0);
    @(posedge clk); #3; rst = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_rst", {63'd0, in_ready}, 64'd1);

    // Directed resolution cases
    out_ready = 1'b1;
    send(`BEQ_CONF, 32'd5, 32'd5, 32'h20, 32'h1000, 1'b1, 32'h1020);
    send(`BLT_CONF, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h2000, 1'b1, 32'h2040);
    send(`BLTU_CONF, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h2000, 1'b1, 32'h2040);
    drain();
    chk("cnt_after_bltu", {32'd0, mispredict_cnt}, 64'd1);
    send(`JIRL_CONF, 32'h2000, 32'd0, 32'h10, 32'h500, 1'b1, 32'h2010);
    send(`JIRL_CONF, 32'h2000, 32'd0, 32'h10, 32'h500, 1'b1, 32'h2014);
    drain();
    chk("cnt_after_jirl", {32'd0, mispredict_cnt}, 64'd2);

    // Backpressure: fill to DEPTH, fifth op waits
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      send(`BNE_CONF, 32'(i), 32'd3, 32'h8, 32'h3000 + 32'(i * 4), 1'b0, 32'd0);
    chk("full_in_ready", {63'd0, in_ready}, 64'd0);
    drive(`BGE_CONF, 32'h8000_0000, 32'd0, 32'h8, 32'h4000, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_hold", {63'd0, in_ready}, 64'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_accept();
    drain();

    // Flush with simultaneous push and pop
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      send(`BGEU_CONF, 32'd9, 32'(i), 32'h10, 32'h5000, 1'b1, 32'h5010);
    drive(`BEQ_CONF, 32'd1, 32'd1, 32'h4, 32'h6000, 1'b0, 32'd0);
    out_ready = 1'b1;
    flush_back = 1'b1;
    @(posedge clk); #1;
    flush_back = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
    repeat (3) @(posedge clk);
    #1;

    // Asynchronous reset with entries pending
    out_ready = 1'b0;
    send(4'd0, 32'd0, 32'd0, 32'd0, 32'h7000, 1'b1, 32'd0);
    send(4'd9, 32'd0, 32'd0, 32'd0, 32'h7004, 1'b1, 32'd0);
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    chk("async_out_valid", {63'd0, out_valid}, 64'd0);
    chk("async_cnt", {32'd0, mispredict_cnt}, 64'd0);
    sb.delete();
    model_cnt = 32'd0;
    @(posedge clk); #3;
    rst = 1'b1;
    @(posedge clk); #1;

    // Counter saturation
    @(negedge clk); #2;
    force dut.cnt_r = 32'hFFFF_FFFE;
    #1;
    release dut.cnt_r;
    model_cnt = 32'hFFFF_FFFE;
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++)
      send(4'd0, 32'd0, 32'd0, 32'd0, 32'h8000, 1'b1, 32'd0);
    drain();
    chk("cnt_saturated", {32'd0, mispredict_cnt}, 64'hFFFF_FFFF);

    // Randomized traffic with random backpressure
    rand_rdy = 1'b1;
    for (int n = 0; n < 250; n++) begin
      c  = 4'($urandom_range(0, 9));
      dj = $urandom;
      dd = ($urandom_range(0, 3) == 0) ? dj : $urandom;
      im = 32'($signed(12'($urandom)));
      p  = {$urandom_range(0, 65535), 2'b00} + 32'h1_0000;
      e  = model(c, dj, dd, im, p, 1'b0, 32'd0, 6'd0);
      tp = ($urandom_range(0, 1) == 1) ? e.target : $urandom;
      send(c, dj, dd, im, p, 1'($urandom_range(0, 1)), tp);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    rand_rdy = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
